parking_gate_arbiter: RTL

//  Controller for a single shared barrier gate serving one entry lane and one exit lane.

---
 rtl/parking_pkg.sv | 25 ++
 rtl/parking_timer.sv | 38 +++
 rtl/parking_gate_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package     : parking_pkg                                             |
// | Description : Shared constants for the parking gate arbiter: FSM      |
// |               state codes, grant direction codes, keypad password.    |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
package parking_pkg;

  // Gate controller states (explicit 2-bit encoding)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OPEN  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_DENY  = 2'd3;

  // Grant direction as presented on dir_in
  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  // Entry keypad password (only consulted when PARKING_PASSWORD_EN is defined)
  localparam logic [1:0] PWD_1 = 2'b01;
  localparam logic [1:0] PWD_2 = 2'b10;

endpackage
`default_nettype wire

// File: rtl/parking_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : parking_timer                                           |
// | Description : Loadable down-counter that stops at zero and flags it.  |
// |               Shared by the OPEN, GUARD and DENY phases.              |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module parking_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Counter register, cleared by the active-low asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : parking_gate_arbiter                                    |
// | Description : Shared barrier gate controller for one entry and one    |
// |               exit lane. Arbitrates requests, opens the gate, waits   |
// |               for the pass sensor, owns the occupancy count and full  |
// |               flag, and denies entry when the lot is full.            |
// | Options     : PARKING_PASSWORD_EN - entry additionally requires the   |
// |               keypad digits to match PWD_1/PWD_2.                     |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 10,
  parameter int CNT_W        = 8,
  parameter int PASS_TIMEOUT = 64,
  parameter int GUARD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_sensor,
  input  logic [1:0]       pwd_1,
  input  logic [1:0]       pwd_2,
  output logic             gate_open,
  output logic             dir_in,
  output logic             green_led,
  output logic             red_led,
  output logic [CNT_W-1:0] count,
  output logic             parking_full,
  output logic             timeout_evt
);

  localparam int TMR_MAX = (PASS_TIMEOUT > GUARD_CYCLES) ? PASS_TIMEOUT : GUARD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] T_PASS_C  = TMR_W'(PASS_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] T_GUARD_C = TMR_W'(GUARD_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;       // doubles as last-grant direction
  logic             full_q;
  logic             gate_q, red_q, tevt_q, tevt_d;

  logic             tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic             pwd_ok, valid_in, valid_out;

`ifdef PARKING_PASSWORD_EN
  assign pwd_ok = (pwd_1 == PWD_1) && (pwd_2 == PWD_2);
`else
  logic unused_pwd;
  assign unused_pwd = ^{pwd_1, pwd_2};
  assign pwd_ok     = 1'b1;
`endif

  // An entry that is not valid while requested ends up in DENY
  assign valid_in  = entry_req && !full_q && pwd_ok;
  assign valid_out = exit_req && (count_q != '0);

  parking_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state, arbitration and saturating count update
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dir_d    = dir_q;
    tevt_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        // On contention alternate against the previous grant
        if (valid_in && (!valid_out || dir_q == DIR_OUT)) begin
          state_d  = ST_OPEN;
          dir_d    = DIR_IN;
          tmr_load = 1'b1;
          tmr_val  = T_PASS_C;
        end else if (valid_out) begin
          state_d  = ST_OPEN;
          dir_d    = DIR_OUT;
          tmr_load = 1'b1;
          tmr_val  = T_PASS_C;
        end else if (entry_req) begin
          state_d  = ST_DENY;
          tmr_load = 1'b1;
          tmr_val  = T_GUARD_C;
        end
      end
      ST_OPEN: begin
        if (pass_sensor) begin
          if (dir_q == DIR_IN && count_q != CAP_C)
            count_d = count_q + 1'b1;
          else if (dir_q == DIR_OUT && count_q != '0)
            count_d = count_q - 1'b1;
          state_d  = ST_GUARD;
          tmr_load = 1'b1;
          tmr_val  = T_GUARD_C;
        end else if (tmr_zero) begin
          tevt_d   = 1'b1;
          state_d  = ST_GUARD;
          tmr_load = 1'b1;
          tmr_val  = T_GUARD_C;
        end
      end
      ST_GUARD: begin
        if (tmr_zero) state_d = ST_IDLE;
      end
      ST_DENY: begin
        // Hold until the denied car has backed off the entry loop
        if (tmr_zero && !entry_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops the gate immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dir_q   <= DIR_OUT;
      full_q  <= 1'b0;
      gate_q  <= 1'b0;
      red_q   <= 1'b0;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      full_q  <= (count_d == CAP_C);
      gate_q  <= (state_d == ST_OPEN);
      red_q   <= (state_d == ST_DENY);
      tevt_q  <= tevt_d;
    end
  end

  assign gate_open    = gate_q;
  assign green_led    = gate_q;
  assign red_led      = red_q;
  assign dir_in       = dir_q;
  assign count        = count_q;
  assign parking_full = full_q;
  assign timeout_evt  = tevt_q;

endmodule
`default_nettype wire
